// File: rtl/jclk_stepper_if.sv
// Control and clock-phase bundle between the stepper and the CPU datapath.
// The master drives halt/resume; the slave (the stepper) drives the phase outputs.
interface jclk_stepper_if #(
  parameter int N = 6
) ();
  logic         whalt;
  logic         wgo;
  logic         wclko;
  logic         wclkd;
  logic         wclke;
  logic         wclks;
  logic [N-1:0] bsteps;
  logic         wrun;
  logic         wlast;

  modport master (
    output whalt, wgo,
    input  wclko, wclkd, wclke, wclks, bsteps, wrun, wlast
  );

  modport slave (
    input  whalt, wgo,
    output wclko, wclkd, wclke, wclks, bsteps, wrun, wlast
  );
endinterface

// File: rtl/jclk_stepper.sv
// Four-phase CPU clock generator with an N-step one-hot instruction stepper,
// a halt-at-end-of-instruction request and a resume pulse.
//
//   state   | meaning
//   RUN     | phases advance every wclk, steps advance when leaving phase 3
//   HALTED  | all strobes low, phase/step frozen at P0/step 1, waits for wgo
module jclk_stepper #(
  parameter int N = 6
) (
  input  logic            wclk,
  input  logic            wreset,
  jclk_stepper_if.slave   bus
);

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} mode_t;

  localparam logic [N-1:0] STEP1 = {{(N-1){1'b0}}, 1'b1};

  mode_t        mode, mode_nx;
  logic [1:0]   phase, phase_nx;
  logic [N-1:0] step, step_nx;
  logic         hold, hold_nx;
  logic         rst_q;

  logic         run_nx;
  logic         clk_nx, clkd_nx;

  // rst_q marks the first cycle after reset: state stays at P0/step 1 so the
  // cycle following release is a full P0 with the enable strobe asserted.
  always_comb begin
    mode_nx  = mode;
    phase_nx = phase;
    step_nx  = step;
    hold_nx  = hold;
    if (mode == HALTED) begin
      if (bus.wgo) begin
        mode_nx  = RUN;
        phase_nx = 2'd0;
        step_nx  = STEP1;
      end
    end else if (rst_q) begin
      hold_nx = hold | bus.whalt;
    end else begin
      phase_nx = phase + 2'd1;
      hold_nx  = hold | bus.whalt;
      if (phase == 2'd3) begin
        if (step[N-1] && (hold || bus.whalt)) begin
          mode_nx  = HALTED;
          phase_nx = 2'd0;
          step_nx  = STEP1;
          hold_nx  = 1'b0;
        end else begin
          step_nx = {step[N-2:0], step[N-1]};
        end
      end
    end
  end

  // Outputs are decoded from next state and registered, so they depend on
  // whalt/wgo only through flops.
  always_comb begin
    run_nx  = (mode_nx == RUN);
    clk_nx  = run_nx && (phase_nx == 2'd0 || phase_nx == 2'd1);
    clkd_nx = run_nx && (phase_nx == 2'd1 || phase_nx == 2'd2);
  end

  always_ff @(posedge wclk) begin
    if (wreset) begin
      mode       <= RUN;
      phase      <= 2'd0;
      step       <= STEP1;
      hold       <= 1'b0;
      rst_q      <= 1'b1;
      bus.wclko  <= 1'b1;
      bus.wclkd  <= 1'b0;
      bus.wclke  <= 1'b0;
      bus.wclks  <= 1'b0;
      bus.wlast  <= 1'b0;
      bus.wrun   <= 1'b1;
      bus.bsteps <= STEP1;
    end else begin
      mode       <= mode_nx;
      phase      <= phase_nx;
      step       <= step_nx;
      hold       <= hold_nx;
      rst_q      <= 1'b0;
      bus.wclko  <= clk_nx;
      bus.wclkd  <= clkd_nx;
      bus.wclke  <= clk_nx | clkd_nx;
      bus.wclks  <= clk_nx & clkd_nx;
      bus.wlast  <= run_nx && (phase_nx == 2'd3) && step_nx[N-1];
      bus.wrun   <= run_nx;
      bus.bsteps <= run_nx ? step_nx : '0;
    end
  end

endmodule

// File: doc/jclk_stepper.md
JCLK_STEPPER -- requirements
Module: jclk_stepper

Interface
REQ-001 Parameter: N, default 6, number of steps per instruction (legal 2..8).
REQ-002 Port: wclk  input  1  base clock; all state updates on rising edge.
REQ-003 Port: wreset  input  1  synchronous, active-high reset.
REQ-004 Port: whalt  input  1  halt request; honoured at end of current instruction.
REQ-005 Port: wgo  input  1  resume pulse; honoured only while halted.
REQ-006 Port: wclko  output  1  CPU clock phase signal (clk).
REQ-007 Port: wclkd  output  1  CPU clock delayed a quarter tick (clkd).
REQ-008 Port: wclke  output  1  enable strobe for registers/enablers (clk OR clkd).
REQ-009 Port: wclks  output  1  set strobe for byte/memory cells (clk AND clkd).
REQ-010 Port: bsteps  output  N  one-hot step vector; bit 0 = step 1.
REQ-011 Port: wrun  output  1  high while sequencing, low while halted.
REQ-012 Port: wlast  output  1  high for exactly one wclk cycle: step N, phase 3.

Function
REQ-013 State: 2-bit phase counter P, step register S (one-hot, N bits), mode RUN/HALTED, halt-pending flag H; all outputs decode from registered state only.
REQ-014 One CPU tick = 4 wclk cycles; P advances 0->1->2->3->0 each wclk in RUN.
REQ-015 Phase decode in RUN: P0 clk=1 clkd=0; P1 1/1; P2 0/1; P3 0/0.
REQ-016 wclke = clk OR clkd, so high in P0-P2; wclks = clk AND clkd, so high in P1 only.
REQ-017 wclks never high in a cycle where wclke is low; wclks pulse is strictly inside the wclke window.
REQ-018 S advances one position on the wclk edge leaving P3; step N wraps to step 1.
REQ-019 bsteps = S in RUN; exactly one bit high at all times in RUN.
REQ-020 whalt high in any RUN cycle sets H; H is cleared only by reset or on entering HALTED.
REQ-021 Edge leaving step N, P3 with H set (or whalt high that same cycle): mode -> HALTED, P=0, S=step 1, H cleared.
REQ-022 HALTED: wclko, wclkd, wclke, wclks, wrun, wlast all 0; bsteps all 0; P and S frozen.
REQ-023 wgo high in HALTED: next cycle mode RUN at P0, step 1; whalt in that same cycle ignored.
REQ-024 wgo in RUN ignored; whalt in HALTED ignored.
REQ-025 whalt held continuously: CPU halts after each instruction; every wgo yields exactly one full instruction (4*N cycles).
REQ-026 No combinational path from whalt or wgo to any output.

Reset
REQ-027 wreset high on a wclk edge: P=0, S=step 1, mode RUN, H=0, overriding whalt and wgo.
REQ-028 While wreset high: wclke=0, wclks=0, wlast=0; wclko=1, wclkd=0, bsteps=1, wrun=1.
REQ-029 First cycle after wreset falls: P0, step 1, wclke=1, wclks=0.
REQ-030 Reset mid-instruction or while halted: same as REQ-027; no partial wclks pulse generated.

Verification
REQ-031 Reset 2 cycles, release, run 8 cycles -> wclke 1,1,1,0,1,1,1,0; wclks 0,1,0,0,0,1,0,0; bsteps 1,1,1,1,2,2,2,2 (one-hot values).
REQ-032 N=6, run 24 cycles from reset -> bsteps reaches 0x20 on cycles 20-23, wlast high only cycle 23, cycle 24 bsteps=0x01.
REQ-033 whalt 1-cycle pulse at cycle 5 -> runs to cycle 23, cycle 24 onward wrun=0, bsteps=0, wclke=0; wgo at cycle 30 -> cycle 31 P0 step 1, wclke=1.
REQ-034 whalt held high, wgo pulsed once -> exactly 24 RUN cycles with 6 wclks pulses, then halted again.
REQ-035 wreset at cycle 10 (step 3 P2) -> cycle 11 wclke=0, wclks=0; after release P0 step 1.
REQ-036 whalt and wgo both high while halted -> resumes; full instruction completes before next halt.
